clk_period_meter: RTL and testbench
===================================

// Module: clk_period_meter
// PURPOSE
//  Receive-side counterpart of the programmable clock/shutter divider: samples an external
//  square wave (IC clock/shutter, or divider output looped back) on the 100 MHz clk and measures
//  the high and low time of each full period in clk cycles. Used to verify shutter timing
//  and to read back IC-generated clocks. Results go to FPGA registers with a 1-cycle valid strobe.
// PARAMETERS
//  CNT_W    32         width of hi/lo counters and results
//  TIMEOUT  1000000    cycles without an edge before the phase is declared stuck (<= 2^CNT_W-1)
//  MCNT_W   16         width of completed-period counter
// PORTS
//  clk            in   1         100 MHz system clock
//  rst            in   1         asynchronous reset, active high
//  en             in   1         measurement enable
//  sig_in         in   1         asynchronous square wave to measure
//  hi_cycles      out  CNT_W     high time of last complete period, in clk cycles
//  lo_cycles      out  CNT_W     low time of last complete period, in clk cycles
//  period_cycles  out  CNT_W+1   hi_cycles + lo_cycles
//  valid          out  1         1-cycle strobe: new hi/lo/period results
//  timeout        out  1         1-cycle strobe: no edge within TIMEOUT cycles
//  stuck_level    out  1         sig level at last timeout
//  meas_count     out  MCNT_W    count of completed periods, wraps at 2^MCNT_W
// BEHAVIOUR
//  - Reset: all outputs, counters and sync flops = 0; state IDLE. Applies immediately, mid-measure too.
//  - sig_in -> 2-flop synchronizer (s) -> 1 more flop (s_d). rise = s & ~s_d; fall = ~s & s_d.
//    Fixed 2-cycle input latency; does not affect measured widths. Phases < 1 clk may be missed.
//  - States: IDLE, ARM, HIGH, LOW.
//    IDLE: cnt=0, hi_tmp=0. en=1 -> ARM.
//    ARM : discard partial phase. rise -> HIGH, cnt<=1. Otherwise stay.
//    HIGH: s=1 -> cnt<=cnt+1. fall -> hi_tmp<=cnt, cnt<=1, -> LOW.
//    LOW : s=0 -> cnt<=cnt+1. rise -> hi_cycles<=hi_tmp, lo_cycles<=cnt,
//          period_cycles<=hi_tmp+cnt (CNT_W+1 bits, no overflow), valid<=1,
//          meas_count<=meas_count+1, cnt<=1, -> HIGH.
//  - Count = number of clk cycles s spent at the level: a divider programmed t_high=N,
//    t_low=M measures hi=N+1, lo=M+1.
//  - Timeout: in HIGH or LOW, when cnt reaches TIMEOUT and no edge this cycle -> timeout<=1 (1 cycle),
//    stuck_level<=s, cnt<=0, -> ARM. No valid. Counters never wrap (TIMEOUT bounds them).
//  - en=0 in any state -> IDLE next cycle; takes priority over a same-cycle edge (no valid, no timeout).
//  - hi/lo/period_cycles, stuck_level, meas_count hold last values outside reset; only updated as above.
//  - valid and timeout are never both 1; both are 0 in every cycle not named above.
//  - Illegal state encoding -> IDLE, counters cleared.
// TESTING
//  1. Divider loopback t_high=3,t_low=5, en=1 -> valid every 10 clk; hi=4, lo=6, period=10, meas_count+1 each.
//  2. en raised mid-high phase (t_high=7,t_low=2) -> no valid on partial period; first valid hi=8, lo=3.
//  3. TIMEOUT=100, sig_in held 1 after a rise -> timeout strobe exactly 100 cycles after rise seen on s,
//     stuck_level=1, valid never asserts; release sig -> ARM, then normal measurement.
//  4. Prior result hi=4,lo=6; en dropped mid-LOW on same cycle as rise -> no valid, outputs keep 4/6/10;
//     en re-raised -> next full period measured correctly.
//  5. t_high=0,t_low=0 -> hi=1, lo=1, period=2, valid every 2 cycles; MCNT_W=4 -> meas_count wraps 15->0.
//  6. Async rst pulse mid-HIGH (between clk edges) -> all outputs 0 immediately; after release, ARM only once en=1.

Source files
------------

// File: rtl/clk_period_meter.sv
// Measures high and low time of each full period of an external square wave, in clk cycles.
// Latency: 2-flop sync + edge flop; results registered on the clk after the closing rise is seen.
// No backpressure: results are 1-cycle strobes that must be captured when valid/timeout is high.
module clk_period_meter #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1000000,
    parameter int MCNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sig_in,
    output logic [CNT_W-1:0]  hi_cycles,
    output logic [CNT_W-1:0]  lo_cycles,
    output logic [CNT_W:0]    period_cycles,
    output logic              valid,
    output logic              timeout,
    output logic              stuck_level,
    output logic [MCNT_W-1:0] meas_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_LOW  = 2'd3;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             sig_meta;
    logic             s;
    logic             s_d;
    logic             rise;
    logic             fall;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi_tmp;

    // Bring the asynchronous input into the clk domain and keep one extra stage for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_meta <= 1'b0;
            s        <= 1'b0;
            s_d      <= 1'b0;
        end else begin
            sig_meta <= sig_in;
            s        <= sig_meta;
            s_d      <= s;
        end
    end

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    // Phase measurement FSM: cnt counts cycles the synchronised level has held; an edge closes
    // the phase, and a phase that reaches TIMEOUT without an edge is abandoned and re-armed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            hi_tmp        <= '0;
            hi_cycles     <= '0;
            lo_cycles     <= '0;
            period_cycles <= '0;
            valid         <= 1'b0;
            timeout       <= 1'b0;
            stuck_level   <= 1'b0;
            meas_count    <= '0;
        end else begin
            valid   <= 1'b0;
            timeout <= 1'b0;
            if (!en) begin
                // Disable wins over any edge or timeout seen in the same cycle.
                state  <= ST_IDLE;
                cnt    <= '0;
                hi_tmp <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        cnt    <= '0;
                        hi_tmp <= '0;
                        state  <= ST_ARM;
                    end
                    ST_ARM: begin
                        // Whatever phase is in progress is partial; wait for a clean rise.
                        if (rise) begin
                            cnt   <= CNT_ONE;
                            state <= ST_HIGH;
                        end else begin
                            cnt <= '0;
                        end
                    end
                    ST_HIGH: begin
                        if (fall) begin
                            hi_tmp <= cnt;
                            cnt    <= CNT_ONE;
                            state  <= ST_LOW;
                        end else if (cnt == TIMEOUT_C) begin
                            timeout     <= 1'b1;
                            stuck_level <= s;
                            cnt         <= '0;
                            state       <= ST_ARM;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    ST_LOW: begin
                        if (rise) begin
                            hi_cycles     <= hi_tmp;
                            lo_cycles     <= cnt;
                            period_cycles <= {1'b0, hi_tmp} + {1'b0, cnt};
                            valid         <= 1'b1;
                            meas_count    <= meas_count + MCNT_W'(1);
                            cnt           <= CNT_ONE;
                            state         <= ST_HIGH;
                        end else if (cnt == TIMEOUT_C) begin
                            timeout     <= 1'b1;
                            stuck_level <= s;
                            cnt         <= '0;
                            state       <= ST_ARM;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        cnt    <= '0;
                        hi_tmp <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: phases of sig_in are driven as (level, length) pairs,
// and expected valid/timeout events (cycle, widths, level) are predicted from those phase lengths.
// Events are checked in order by a monitor on the falling clock edge.
module tb_clk_period_meter;

    localparam int CNT_W   = 32;
    localparam int TO      = 100;
    localparam int MCNT_W  = 4;

    logic              clk;
    logic              rst;
    logic              en;
    logic              sig_in;
    logic [CNT_W-1:0]  hi_cycles;
    logic [CNT_W-1:0]  lo_cycles;
    logic [CNT_W:0]    period_cycles;
    logic              valid;
    logic              timeout;
    logic              stuck_level;
    logic [MCNT_W-1:0] meas_count;

    clk_period_meter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TO),
        .MCNT_W  (MCNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .sig_in        (sig_in),
        .hi_cycles     (hi_cycles),
        .lo_cycles     (lo_cycles),
        .period_cycles (period_cycles),
        .valid         (valid),
        .timeout       (timeout),
        .stuck_level   (stuck_level),
        .meas_count    (meas_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int at;
        bit is_to;
        int hi;
        int lo;
        bit lvl;
    } ev_t;

    ev_t exp_q[$];

    // Reference model state, expressed over whole phases of the input waveform.
    bit on      = 1'b0;  // enable currently high
    bit armed   = 1'b0;  // waiting for a rise to start measuring
    bit hi_ok   = 1'b0;  // current high phase began with a counted rise
    bit lo_ok   = 1'b0;  // current low phase followed a counted high phase
    bit cur_lvl = 1'b0;
    int hi_len  = 0;
    int lo_len  = 0;

    // Monitor-side bookkeeping of what the outputs should hold.
    int mc_exp  = 0;
    int last_hi = 0;
    int last_lo = 0;
    ev_t mon_e;

    always @(negedge clk) begin
        if (!rst && (valid || timeout)) begin
            check("valid_and_timeout", 64'(valid & timeout), 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_event", 64'({valid, timeout}), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_kind", 64'(timeout), 64'(mon_e.is_to));
                check("event_cycle", 64'(cyc), 64'(mon_e.at));
                if (!mon_e.is_to) begin
                    mc_exp  = (mc_exp + 1) % (1 << MCNT_W);
                    last_hi = mon_e.hi;
                    last_lo = mon_e.lo;
                    check("hi_cycles", 64'(hi_cycles), 64'(mon_e.hi));
                    check("lo_cycles", 64'(lo_cycles), 64'(mon_e.lo));
                    check("period_cycles", 64'(period_cycles), 64'(mon_e.hi + mon_e.lo));
                    check("meas_count", 64'(meas_count), 64'(mc_exp));
                end else begin
                    check("stuck_level", 64'(stuck_level), 64'(mon_e.lvl));
                    check("hi_hold_on_timeout", 64'(hi_cycles), 64'(last_hi));
                    check("lo_hold_on_timeout", 64'(lo_cycles), 64'(last_lo));
                end
            end
        end
    end

    // Drive one phase of sig_in; caller is 1 time unit after a rising edge.
    // A change driven after edge d is seen by the meter at edge d+3.
    task automatic phase(input bit lvl, input int len);
        int d;
        d = cyc;
        sig_in = lvl;
        if (on && lvl != cur_lvl) begin
            if (lvl) begin
                if (lo_ok)
                    exp_q.push_back('{at: d + 3, is_to: 1'b0, hi: hi_len, lo: lo_len, lvl: 1'b0});
                hi_ok = armed || lo_ok;
                lo_ok = 1'b0;
                if (hi_ok) begin
                    armed  = 1'b0;
                    hi_len = len;
                    if (len > TO) begin
                        exp_q.push_back('{at: d + 3 + TO, is_to: 1'b1, hi: 0, lo: 0, lvl: 1'b1});
                        hi_ok = 1'b0;
                        armed = 1'b1;
                    end
                end
            end else begin
                lo_ok = hi_ok;
                hi_ok = 1'b0;
                if (lo_ok) begin
                    lo_len = len;
                    if (len > TO) begin
                        exp_q.push_back('{at: d + 3 + TO, is_to: 1'b1, hi: 0, lo: 0, lvl: 1'b0});
                        lo_ok = 1'b0;
                        armed = 1'b1;
                    end
                end
            end
        end
        cur_lvl = lvl;
        repeat (len) @(posedge clk);
        #1;
    endtask

    task automatic en_on();
        en    = 1'b1;
        on    = 1'b1;
        armed = 1'b1;
        hi_ok = 1'b0;
        lo_ok = 1'b0;
    endtask

    // Anything predicted for the edge that first sees en low, or later, cannot happen.
    task automatic en_off();
        en = 1'b0;
        on = 1'b0;
        while (exp_q.size() > 0 && exp_q[$].at > cyc) void'(exp_q.pop_back());
    endtask

    function automatic int pick_len();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(TO - 2, TO + 3));
        return int'($urandom_range(1, 15));
    endfunction

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hi_cycles", 64'(hi_cycles), 64'd0);
        check("rst_lo_cycles", 64'(lo_cycles), 64'd0);
        check("rst_period", 64'(period_cycles), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_stuck", 64'(stuck_level), 64'd0);
        check("rst_meas_count", 64'(meas_count), 64'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Divider loopback t_high=3, t_low=5: periods of 4 high + 6 low.
        en_on();
        phase(1'b0, 5);
        repeat (6) begin
            phase(1'b1, 4);
            phase(1'b0, 6);
        end
        phase(1'b1, 4);
        en_off();
        phase(1'b0, 4);

        // Enable raised in the middle of a high phase (t_high=7, t_low=2).
        phase(1'b1, 3);
        en_on();
        phase(1'b1, 5);
        phase(1'b0, 3);
        phase(1'b1, 8);
        phase(1'b0, 3);
        phase(1'b1, 8);
        phase(1'b0, 3);
        phase(1'b1, 2);
        en_off();
        phase(1'b0, 4);

        // Stuck levels and the exact timeout boundary.
        en_on();
        phase(1'b0, 4);
        phase(1'b1, 150);
        phase(1'b0, 6);
        phase(1'b1, 4);
        phase(1'b0, 6);
        phase(1'b1, 4);
        phase(1'b0, TO);
        phase(1'b1, TO);
        phase(1'b0, TO + 1);
        phase(1'b1, 4);
        phase(1'b0, 6);
        phase(1'b1, 5);
        phase(1'b0, 130);
        phase(1'b1, 4);
        en_off();
        phase(1'b0, 4);

        // Enable dropped on the cycle a closing rise reaches the meter.
        en_on();
        phase(1'b0, 4);
        phase(1'b1, 4);
        phase(1'b0, 6);
        phase(1'b1, 4);
        phase(1'b0, 6);
        phase(1'b1, 2);
        en_off();
        phase(1'b1, 5);
        check("hold_hi_after_disable", 64'(hi_cycles), 64'd4);
        check("hold_lo_after_disable", 64'(lo_cycles), 64'd6);
        check("hold_period_after_disable", 64'(period_cycles), 64'd10);
        check("hold_count_after_disable", 64'(meas_count), 64'(mc_exp));
        phase(1'b0, 4);
        en_on();
        phase(1'b0, 3);
        phase(1'b1, 5);
        phase(1'b0, 7);
        phase(1'b1, 5);
        phase(1'b0, 7);
        phase(1'b1, 3);
        en_off();
        phase(1'b0, 4);

        // Fastest divider setting and meas_count wrap.
        en_on();
        phase(1'b0, 4);
        repeat (20) begin
            phase(1'b1, 1);
            phase(1'b0, 1);
        end
        phase(1'b1, 3);
        en_off();
        phase(1'b0, 4);

        // Random phase lengths, some straddling the timeout.
        en_on();
        phase(1'b0, 4);
        repeat (40) begin
            phase(1'b1, pick_len());
            phase(1'b0, pick_len());
        end
        phase(1'b1, 3);
        en_off();
        phase(1'b0, 4);

        // Asynchronous reset in the middle of a high phase.
        en_on();
        phase(1'b0, 4);
        phase(1'b1, 4);
        phase(1'b0, 6);
        phase(1'b1, 6);
        #2;
        rst = 1'b1;
        #1;
        check("arst_hi_cycles", 64'(hi_cycles), 64'd0);
        check("arst_lo_cycles", 64'(lo_cycles), 64'd0);
        check("arst_period", 64'(period_cycles), 64'd0);
        check("arst_meas_count", 64'(meas_count), 64'd0);
        check("arst_valid", 64'(valid), 64'd0);
        exp_q.delete();
        mc_exp  = 0;
        last_hi = 0;
        last_lo = 0;
        en      = 1'b0;
        on      = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_meas_count", 64'(meas_count), 64'd0);
        phase(1'b0, 4);
        phase(1'b1, 4);
        phase(1'b0, 6);
        phase(1'b1, 4);
        check("no_meas_while_disabled", 64'(meas_count), 64'd0);
        en_on();
        phase(1'b0, 6);
        phase(1'b1, 4);
        phase(1'b0, 6);
        phase(1'b1, 4);
        phase(1'b0, 3);
        en_off();
        phase(1'b0, 4);
        check("post_rst_first_count", 64'(meas_count), 64'd1);

        repeat (5) @(posedge clk);
        #1;
        check("pending_events", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
